network_interface_param: RTL and testbench

NETWORK_INTERFACE_PARAM -- requirements
Module: network_interface_param

---
 rtl/network_interface_param.sv | 199 +++++++++++++++++++
 tb/tb_network_interface_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/network_interface_param.sv
// CPU-to-router network interface: CPU writes become TX packets, router packets
// queue in an RX FIFO that the CPU drains through a small register map.
module network_interface_param #(
    parameter int DATA_W    = 32,
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8,
    parameter int RX_THRESH = 4,
    localparam int PKT_W    = 32 + DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [PKT_W-1:0]  rtr_tx_data,
    output logic              rtr_tx_valid,
    input  logic              rtr_tx_ready,
    input  logic [PKT_W-1:0]  rtr_rx_data,
    input  logic              rtr_rx_valid,
    output logic              rtr_rx_ready,
    output logic              irq
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW-1:0] TX_PTR_ONE = TX_AW'(1);
    localparam logic [RX_AW-1:0] RX_PTR_ONE = RX_AW'(1);
    localparam logic [TX_AW:0]   TX_CNT_ONE = (TX_AW + 1)'(1);
    localparam logic [RX_AW:0]   RX_CNT_ONE = (RX_AW + 1)'(1);
    localparam logic [TX_AW:0]   TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0]   RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [RX_AW:0]   RX_IRQ_CNT = (RX_AW + 1)'(RX_THRESH);

    localparam logic [31:0] ADDR_RX_POP  = 32'h0000_0000;
    localparam logic [31:0] ADDR_RX_DATA = 32'h0000_0004;
    localparam logic [31:0] ADDR_STATUS  = 32'h0000_0008;
    localparam logic [31:0] ADDR_CTRL    = 32'h0000_000C;

    logic [PKT_W-1:0]  tx_mem_q [TX_DEPTH];
    logic [PKT_W-1:0]  tx_mem_d [TX_DEPTH];
    logic [PKT_W-1:0]  rx_mem_q [RX_DEPTH];
    logic [PKT_W-1:0]  rx_mem_d [RX_DEPTH];
    logic [TX_AW-1:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [RX_AW-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [TX_AW:0]    tx_count_q, tx_count_d;
    logic [RX_AW:0]    rx_count_q, rx_count_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic              rx_udf_q, rx_udf_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    logic              tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic              tx_wr_s, ctrl_wr_s, rx_pop_rd_s;
    logic              tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic [PKT_W-1:0]  rx_head_s;
    logic [DATA_W-1:0] status_s;

    assign tx_full_s    = (tx_count_q == TX_FULL_CNT);
    assign tx_empty_s   = (tx_count_q == '0);
    assign rx_full_s    = (rx_count_q == RX_FULL_CNT);
    assign rx_empty_s   = (rx_count_q == '0);
    assign tx_wr_s      = cpu_we && (cpu_addr != ADDR_CTRL);
    assign ctrl_wr_s    = cpu_we && (cpu_addr == ADDR_CTRL);
    assign rx_pop_rd_s  = cpu_re && (cpu_addr == ADDR_RX_POP);
    assign tx_push_s    = tx_wr_s && !tx_full_s;
    assign tx_pop_s     = !tx_empty_s && rtr_tx_ready;
    assign rx_push_s    = rtr_rx_valid && rtr_rx_ready;
    assign rx_pop_s     = rx_pop_rd_s && !rx_empty_s;
    assign rx_head_s    = rx_mem_q[rx_rptr_q];
    // Ready is gated by rst_n so the router sees back-pressure throughout reset.
    assign rtr_rx_ready = rst_n && !rx_full_s;
    assign rtr_tx_valid = !tx_empty_s;
    assign rtr_tx_data  = tx_mem_q[tx_rptr_q];
    assign irq          = irq_q;

    // FIFO next-state: storage, pointers and occupancy counts.
    always_comb begin
        for (int i = 0; i < TX_DEPTH; i++) begin
            tx_mem_d[i] = (tx_push_s && (tx_wptr_q == TX_AW'(i))) ? {cpu_addr, cpu_wdata} : tx_mem_q[i];
        end
        for (int i = 0; i < RX_DEPTH; i++) begin
            rx_mem_d[i] = (rx_push_s && (rx_wptr_q == RX_AW'(i))) ? rtr_rx_data : rx_mem_q[i];
        end
        tx_wptr_d = tx_push_s ? (tx_wptr_q + TX_PTR_ONE) : tx_wptr_q;
        tx_rptr_d = tx_pop_s  ? (tx_rptr_q + TX_PTR_ONE) : tx_rptr_q;
        rx_wptr_d = rx_push_s ? (rx_wptr_q + RX_PTR_ONE) : rx_wptr_q;
        rx_rptr_d = rx_pop_s  ? (rx_rptr_q + RX_PTR_ONE) : rx_rptr_q;
        if (tx_push_s && !tx_pop_s) begin
            tx_count_d = tx_count_q + TX_CNT_ONE;
        end else if (!tx_push_s && tx_pop_s) begin
            tx_count_d = tx_count_q - TX_CNT_ONE;
        end else begin
            tx_count_d = tx_count_q;
        end
        if (rx_push_s && !rx_pop_s) begin
            rx_count_d = rx_count_q + RX_CNT_ONE;
        end else if (!rx_push_s && rx_pop_s) begin
            rx_count_d = rx_count_q - RX_CNT_ONE;
        end else begin
            rx_count_d = rx_count_q;
        end
    end

    // Control/status next-state; a set in the same cycle as a clear wins.
    always_comb begin
        irq_en_d  = ctrl_wr_s ? cpu_wdata[0] : irq_en_q;
        rx_data_d = rx_pop_s ? rx_head_s[DATA_W-1:0] : rx_data_q;
        if (tx_wr_s && tx_full_s) begin
            tx_ovf_d = 1'b1;
        end else if (ctrl_wr_s && cpu_wdata[4]) begin
            tx_ovf_d = 1'b0;
        end else begin
            tx_ovf_d = tx_ovf_q;
        end
        if (rx_pop_rd_s && rx_empty_s) begin
            rx_udf_d = 1'b1;
        end else if (ctrl_wr_s && cpu_wdata[5]) begin
            rx_udf_d = 1'b0;
        end else begin
            rx_udf_d = rx_udf_q;
        end
        // Uses the registered count, so irq trails the count by one cycle.
        irq_d = irq_en_q && (rx_count_q >= RX_IRQ_CNT);
    end

    // STATUS word assembly.
    always_comb begin
        status_s        = '0;
        status_s[0]     = rx_empty_s;
        status_s[1]     = rx_full_s;
        status_s[2]     = tx_empty_s;
        status_s[3]     = tx_full_s;
        status_s[4]     = tx_ovf_q;
        status_s[5]     = rx_udf_q;
        status_s[6]     = irq_en_q;
        status_s[15:8]  = 8'(rx_count_q);
        status_s[23:16] = 8'(tx_count_q);
    end

    // CPU read mux.
    always_comb begin
        cpu_rdata = '0;
        if (cpu_re) begin
            case (cpu_addr)
                ADDR_RX_POP: begin
                    if (!rx_empty_s) begin
                        cpu_rdata = DATA_W'(rx_head_s[PKT_W-1:DATA_W]);
                    end else begin
                        cpu_rdata = '0;
                    end
                end
                ADDR_RX_DATA: cpu_rdata = rx_data_q;
                ADDR_STATUS:  cpu_rdata = status_s;
                default:      cpu_rdata = '0;
            endcase
        end else begin
            cpu_rdata = '0;
        end
    end

    // FIFO storage; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_count_q <= '0;
            rx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_udf_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_udf_q   <= rx_udf_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            rx_data_q  <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_network_interface_param.sv
// Directed, table-driven bench for network_interface_param with default parameters.
module tb_network_interface_param;

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic [63:0] rtr_tx_data;
    logic        rtr_tx_valid;
    logic        rtr_tx_ready;
    logic [63:0] rtr_rx_data;
    logic        rtr_rx_valid;
    logic        rtr_rx_ready;
    logic        irq;

    network_interface_param dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata),
        .rtr_tx_data(rtr_tx_data), .rtr_tx_valid(rtr_tx_valid), .rtr_tx_ready(rtr_tx_ready),
        .rtr_rx_data(rtr_rx_data), .rtr_rx_valid(rtr_rx_valid), .rtr_rx_ready(rtr_rx_ready),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        txr;
        logic        rxv;
        logic [63:0] rxd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_txv;
        logic [63:0] exp_txd;
        logic        exp_irq;
        logic        exp_rxr;
    } vec_t;

    vec_t vecs [160];
    int   n_vec;
    int   n_checks;
    int   n_fail;

    function automatic logic [63:0] pkt(input int a, input int d);
        return {32'(a), 32'(d)};
    endfunction

    task automatic add(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic txr, input logic rxv, input logic [63:0] rxd,
                       input logic chk_rd, input logic [31:0] exp_rd,
                       input logic exp_txv, input logic [63:0] exp_txd,
                       input logic exp_irq, input logic exp_rxr);
        vecs[n_vec] = '{we, re, addr, wdata, txr, rxv, rxd, chk_rd, exp_rd, exp_txv, exp_txd, exp_irq, exp_rxr};
        n_vec++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        rtr_tx_ready = 1'b0; rtr_rx_valid = 1'b0; rtr_rx_data = 64'h0;
    endtask

    initial begin
        n_vec = 0; n_checks = 0; n_fail = 0;
        rst_n = 1'b0;
        idle_inputs();

        // TX path: single write, hold, full FIFO with overflow, drain.
        add(0, 1, 32'h8, 0, 0, 0, 0, 1, 32'h0000_0005, 0, 0, 0, 1);
        add(1, 0, 32'h5, 32'hA5, 0, 0, 0, 0, 0, 1, pkt(5, 32'hA5), 0, 1);
        add(0, 1, 32'h8, 0, 0, 0, 0, 1, 32'h0001_0001, 1, pkt(5, 32'hA5), 0, 1);
        add(0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            add(1, 0, 32'h10 + 32'(i), 32'(i + 1), 0, 0, 0, 0, 0, 1, pkt(16, 1), 0, 1);
        add(0, 1, 32'h8, 0, 0, 0, 0, 1, 32'h0008_0009, 1, pkt(16, 1), 0, 1);
        add(1, 0, 32'h20, 32'hFF, 1, 0, 0, 0, 0, 1, pkt(17, 2), 0, 1);
        add(0, 1, 32'h8, 0, 0, 0, 0, 1, 32'h0007_0011, 1, pkt(17, 2), 0, 1);
        add(1, 0, 32'hC, 32'h10, 0, 0, 0, 0, 0, 1, pkt(17, 2), 0, 1);
        add(0, 1, 32'h8, 0, 0, 0, 0, 1, 32'h0007_0001, 1, pkt(17, 2), 0, 1);
        for (int j = 0; j < 7; j++)
            add(0, 0, 32'h0, 0, 1, 0, 0, 0, 0, (j < 6), pkt(18 + j, 3 + j), 0, 1);

        // RX path: pop/data, underflow, irq threshold, full with pop+arrival.
        add(0, 0, 32'h0, 0, 0, 1, pkt(3, 32'h1234), 0, 0, 0, 0, 0, 1);
        add(0, 1, 32'h0, 0, 0, 0, 0, 1, 32'h3, 0, 0, 0, 1);
        add(0, 1, 32'h4, 0, 0, 0, 0, 1, 32'h1234, 0, 0, 0, 1);
        add(0, 1, 32'h8, 0, 0, 0, 0, 1, 32'h0000_0005, 0, 0, 0, 1);
        add(0, 1, 32'h0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 1);
        add(0, 1, 32'h8, 0, 0, 0, 0, 1, 32'h0000_0025, 0, 0, 0, 1);
        add(0, 1, 32'h4, 0, 0, 0, 0, 1, 32'h1234, 0, 0, 0, 1);
        add(1, 0, 32'hC, 32'h21, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 32'h8, 0, 0, 0, 0, 1, 32'h0000_0045, 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++)
            add(0, 0, 32'h0, 0, 0, 1, pkt(k, 32'h100 + k), 0, 0, 0, 0, 0, 1);
        add(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 32'h0, 0, 0, 0, 0, 1, 32'h1, 0, 0, 1, 1);
        add(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 5; k <= 9; k++)
            add(0, 0, 32'h0, 0, 0, 1, pkt(k, 32'h100 + k), 0, 0, 0, 0, (k >= 6), (k != 9));
        add(0, 1, 32'h0, 0, 0, 1, pkt(10, 32'h10A), 1, 32'h2, 0, 0, 1, 1);
        add(0, 1, 32'h8, 0, 0, 1, pkt(10, 32'h10A), 1, 32'h0000_0744, 0, 0, 1, 0);
        add(0, 1, 32'h8, 0, 0, 0, 0, 1, 32'h0000_0846, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++)
            add(0, 1, 32'h0, 0, 0, 0, 0, 1, 32'(3 + k), 0, 0, (k < 5), 1);
        add(0, 1, 32'h4, 0, 0, 0, 0, 1, 32'h10A, 0, 0, 0, 1);
        add(1, 1, 32'h8, 32'h77, 0, 0, 0, 1, 32'h0000_0045, 1, pkt(8, 32'h77), 0, 1);

        // Reset state.
        @(negedge clk);
        #1 check("reset rx_ready", 64'(rtr_rx_ready), 64'd0);
        @(posedge clk);
        #1;
        check("reset tx_valid", 64'(rtr_tx_valid), 64'd0);
        check("reset irq", 64'(irq), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk);
            cpu_we = vecs[i].we; cpu_re = vecs[i].re; cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
            rtr_tx_ready = vecs[i].txr; rtr_rx_valid = vecs[i].rxv; rtr_rx_data = vecs[i].rxd;
            #1;
            if (vecs[i].chk_rd) check($sformatf("v%0d rdata", i), 64'(cpu_rdata), 64'(vecs[i].exp_rd));
            @(posedge clk);
            #1;
            check($sformatf("v%0d tx_valid", i), 64'(rtr_tx_valid), 64'(vecs[i].exp_txv));
            if (vecs[i].exp_txv) check($sformatf("v%0d tx_data", i), rtr_tx_data, vecs[i].exp_txd);
            check($sformatf("v%0d irq", i), 64'(irq), 64'(vecs[i].exp_irq));
            check($sformatf("v%0d rx_ready", i), 64'(rtr_rx_ready), 64'(vecs[i].exp_rxr));
        end

        // Mid-run reset with TX non-empty, then traffic in the first cycle after release.
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1 check("rst2 rx_ready low", 64'(rtr_rx_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rst2 tx_valid", 64'(rtr_tx_valid), 64'd0);
        check("rst2 irq", 64'(irq), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_re = 1'b1; cpu_addr = 32'h8;
        rtr_rx_valid = 1'b1; rtr_rx_data = pkt(7, 32'h77);
        #1 check("rst2 status", 64'(cpu_rdata), 64'h5);
        @(posedge clk);
        #1 check("rst2 rx_ready", 64'(rtr_rx_ready), 64'd1);
        @(negedge clk);
        rtr_rx_valid = 1'b0; cpu_addr = 32'h4;
        #1 check("rst2 rx_data cleared", 64'(cpu_rdata), 64'h0);
        @(negedge clk);
        cpu_addr = 32'h0;
        #1 check("rst2 first rx pop", 64'(cpu_rdata), 64'h7);
        @(negedge clk);
        cpu_addr = 32'h4;
        #1 check("rst2 rx_data latched", 64'(cpu_rdata), 64'h77);
        @(negedge clk);
        cpu_re = 1'b0;
        #1 check("rdata with re low", 64'(cpu_rdata), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
